// File: rtl/rd_valid_gen_pkg.sv
// Shared definitions for the per-lane read-valid generator: FSM encoding,
// default latency geometry and the latency-code clamp.
package rd_valid_gen_pkg;

    localparam logic S_RUN  = 1'b0;
    localparam logic S_PEND = 1'b1;

    localparam int DEF_MAX_LAT   = 16;
    localparam int DEF_LAT_WIDTH = 4;

    // Out-of-range codes saturate to the deepest usable tap.
    function automatic int unsigned clamp_lat(input int unsigned code, input int unsigned max_lat);
        return (code >= max_lat) ? (max_lat - 1) : code;
    endfunction

endpackage

// File: rtl/rd_valid_dly_lane.sv
// One lane of the read-valid delay: shift register fed by dfi_rddata_en,
// latency tap mux and registered, enable-masked valid output.
module rd_valid_dly_lane
    import rd_valid_gen_pkg::*;
#(
    parameter int MAX_LAT   = DEF_MAX_LAT,
    parameter int LAT_WIDTH = DEF_LAT_WIDTH
) (
    input  logic                 SCLK,
    input  logic                 reset_n,
    input  logic                 req_i,
    input  logic                 flush_i,
    input  logic                 enable_i,
    input  logic [LAT_WIDTH-1:0] lat_i,
    output logic                 tap_o,
    output logic                 last_o,
    output logic                 valid_o
);
    localparam int TAPS = 1 << LAT_WIDTH;

    logic [MAX_LAT-1:0] sr_q;
    logic [MAX_LAT-1:0] sr_d;
    logic [TAPS-1:0]    sr_ext;
    logic               valid_q;
    logic               valid_d;

    // A latency change drops stale bits that already passed the old tap,
    // so they cannot resurface at a deeper new tap.
    always_comb begin
        if (flush_i) begin
            sr_d = {{(MAX_LAT-1){1'b0}}, req_i};
        end else begin
            sr_d = {sr_q[MAX_LAT-2:0], req_i};
        end
    end

    assign sr_ext  = TAPS'(sr_q);
    assign tap_o   = sr_ext[lat_i];
    assign last_o  = sr_q[MAX_LAT-1];
    assign valid_d = tap_o & enable_i;
    assign valid_o = valid_q;

    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            sr_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/rd_valid_gen.sv
// Per-lane read-valid generator: delays dfi_rddata_en by a trained per-lane
// latency; latency updates wait for an empty pipeline. Optional per-lane
// valid counters are built when RD_VALID_GEN_STATS_EN is defined.
module rd_valid_gen
    import rd_valid_gen_pkg::*;
#(
    parameter int IOG_DQS_LANES = 2,
    parameter int MAX_LAT       = DEF_MAX_LAT,
    parameter int LAT_WIDTH     = DEF_LAT_WIDTH,
    parameter int CNT_WIDTH     = 5
) (
    input  logic                               SCLK,
    input  logic                               reset_n,
    input  logic                               dfi_rddata_en,
    input  logic [IOG_DQS_LANES*LAT_WIDTH-1:0] lane_rd_lat,
    input  logic                               lat_load,
    input  logic [IOG_DQS_LANES-1:0]           lane_enable,
`ifdef RD_VALID_GEN_STATS_EN
    input  logic                               stats_clr,
    output logic [IOG_DQS_LANES*16-1:0]        lane_valid_cnt,
`endif
    output logic [IOG_DQS_LANES-1:0]           iog_rddata_valid_pre,
    output logic                               lat_busy,
    output logic [IOG_DQS_LANES*LAT_WIDTH-1:0] lat_active,
    output logic [CNT_WIDTH-1:0]               inflight,
    output logic                               lat_err
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                               state_q, state_d;
    logic [IOG_DQS_LANES*LAT_WIDTH-1:0] pend_lat_q, pend_lat_d;
    logic [IOG_DQS_LANES*LAT_WIDTH-1:0] lat_active_q, lat_active_d;
    logic [CNT_WIDTH-1:0]               inflight_q, inflight_d;
    logic                               lat_err_q, lat_err_d;

    logic [IOG_DQS_LANES*LAT_WIDTH-1:0] load_lat;
    logic [IOG_DQS_LANES-1:0]           code_bad;
    logic [IOG_DQS_LANES-1:0]           lane_tap;
    logic [IOG_DQS_LANES-1:0]           lane_last;
    logic                               apply;
    logic                               dec;

    genvar gi;
    generate
        for (gi = 0; gi < IOG_DQS_LANES; gi++) begin : g_lane
            assign code_bad[gi] = (32'(lane_rd_lat[gi*LAT_WIDTH +: LAT_WIDTH]) >= MAX_LAT);
            assign load_lat[gi*LAT_WIDTH +: LAT_WIDTH] =
                LAT_WIDTH'(clamp_lat(32'(lane_rd_lat[gi*LAT_WIDTH +: LAT_WIDTH]), MAX_LAT));

            rd_valid_dly_lane #(
                .MAX_LAT   (MAX_LAT),
                .LAT_WIDTH (LAT_WIDTH)
            ) u_lane (
                .SCLK     (SCLK),
                .reset_n  (reset_n),
                .req_i    (dfi_rddata_en),
                .flush_i  (apply),
                .enable_i (lane_enable[gi]),
                .lat_i    (lat_active_q[gi*LAT_WIDTH +: LAT_WIDTH]),
                .tap_o    (lane_tap[gi]),
                .last_o   (lane_last[gi]),
                .valid_o  (iog_rddata_valid_pre[gi])
            );
        end
    endgenerate

    // Retire a request at the deepest enabled tap. All delay lines carry the
    // same bits, so with every lane disabled the OR of last stages is that tap.
    always_comb begin
        logic                 any_en;
        logic [LAT_WIDTH-1:0] slow_lat;
        any_en   = 1'b0;
        slow_lat = '0;
        dec      = |lane_last;
        for (int i = 0; i < IOG_DQS_LANES; i++) begin
            if (lane_enable[i] &&
                (!any_en || (lat_active_q[i*LAT_WIDTH +: LAT_WIDTH] > slow_lat))) begin
                any_en   = 1'b1;
                slow_lat = lat_active_q[i*LAT_WIDTH +: LAT_WIDTH];
                dec      = lane_tap[i];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (dfi_rddata_en && !dec) begin
            if (inflight_q != CNT_MAX) begin
                inflight_d = inflight_q + 1'b1;
            end
        end else if (!dfi_rddata_en && dec) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - 1'b1;
            end
        end
    end

    // A fresh load always wins over applying the previous pending value.
    always_comb begin
        state_d      = state_q;
        pend_lat_d   = pend_lat_q;
        lat_active_d = lat_active_q;
        lat_err_d    = lat_err_q | (lat_load & (|code_bad));
        apply        = 1'b0;
        if (lat_load) begin
            pend_lat_d = load_lat;
            state_d    = S_PEND;
        end else if ((state_q == S_PEND) && (inflight_q == '0) && !dfi_rddata_en) begin
            lat_active_d = pend_lat_q;
            state_d      = S_RUN;
            apply        = 1'b1;
        end
    end

    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RUN;
            pend_lat_q   <= '0;
            lat_active_q <= '0;
            inflight_q   <= '0;
            lat_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_lat_q   <= pend_lat_d;
            lat_active_q <= lat_active_d;
            inflight_q   <= inflight_d;
            lat_err_q    <= lat_err_d;
        end
    end

    assign lat_busy   = (state_q == S_PEND);
    assign lat_active = lat_active_q;
    assign inflight   = inflight_q;
    assign lat_err    = lat_err_q;

`ifdef RD_VALID_GEN_STATS_EN
    generate
        for (gi = 0; gi < IOG_DQS_LANES; gi++) begin : g_stats
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (stats_clr) begin
                    cnt_d = '0;
                end else if (iog_rddata_valid_pre[gi] && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge SCLK or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign lane_valid_cnt[gi*16 +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_rd_valid_gen.sv
// Scoreboard bench for rd_valid_gen: expected valid cycles are queued per lane
// when requests are driven and matched when the DUT raises each valid.
module tb_rd_valid_gen;

    logic       SCLK          = 1'b0;
    logic       reset_n       = 1'b0;
    logic       dfi_rddata_en = 1'b0;
    logic [7:0] lane_rd_lat   = '0;
    logic       lat_load      = 1'b0;
    logic [1:0] lane_enable   = 2'b11;
    logic [1:0] iog_rddata_valid_pre;
    logic       lat_busy;
    logic [7:0] lat_active;
    logic [4:0] inflight;
    logic       lat_err;
`ifdef RD_VALID_GEN_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] lane_valid_cnt;
`endif

    rd_valid_gen #(
        .IOG_DQS_LANES (2),
        .MAX_LAT       (8),
        .LAT_WIDTH     (4),
        .CNT_WIDTH     (5)
    ) dut (
        .SCLK                 (SCLK),
        .reset_n              (reset_n),
        .dfi_rddata_en        (dfi_rddata_en),
        .lane_rd_lat          (lane_rd_lat),
        .lat_load             (lat_load),
        .lane_enable          (lane_enable),
`ifdef RD_VALID_GEN_STATS_EN
        .stats_clr            (stats_clr),
        .lane_valid_cnt       (lane_valid_cnt),
`endif
        .iog_rddata_valid_pre (iog_rddata_valid_pre),
        .lat_busy             (lat_busy),
        .lat_active           (lat_active),
        .inflight             (inflight),
        .lat_err              (lat_err)
    );

    always #5 SCLK = ~SCLK;

    int cyc = 0;
    always @(posedge SCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int q0[$];
    int q1[$];
    int exp_lat0 = 0;
    int exp_lat1 = 0;
    int peak = 0;
    int s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic tick();
        @(negedge SCLK);
    endtask

    // Drives n back-to-back requests; each is sampled at cyc+1 and appears at cyc+1+lat+1.
    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            dfi_rddata_en = 1'b1;
            if (lane_enable[0]) q0.push_back(cyc + 2 + exp_lat0);
            if (lane_enable[1]) q1.push_back(cyc + 2 + exp_lat1);
            tick();
        end
        dfi_rddata_en = 1'b0;
    endtask

    task automatic load(input logic [7:0] code, input logic [7:0] eff);
        lane_rd_lat = code;
        lat_load    = 1'b1;
        tick();
        lat_load = 1'b0;
        chk("load_busy_set", 32'(lat_busy), 1);
        tick();
        chk("load_lat_active", 32'(lat_active), 32'(eff));
        chk("load_busy_clr", 32'(lat_busy), 0);
        exp_lat0 = int'(eff[3:0]);
        exp_lat1 = int'(eff[7:4]);
    endtask

    task automatic mon_lane(input int ln, input logic v);
        bit have;
        int head;
        have = (ln == 0) ? (q0.size() > 0) : (q1.size() > 0);
        head = 0;
        if (have) head = (ln == 0) ? q0[0] : q1[0];
        if (v) begin
            if (!have) begin
                chk($sformatf("lane%0d_stray", ln), 32'(v), 0);
            end else begin
                chk($sformatf("lane%0d_valid_cycle", ln), 32'(cyc), 32'(head));
                if (ln == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end else if (have && head <= cyc) begin
            chk($sformatf("lane%0d_miss_at_%0d", ln, head), 32'(v), 1);
            if (ln == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    always @(negedge SCLK) begin
        if (reset_n) begin
            if (int'(inflight) > peak) peak = int'(inflight);
            mon_lane(0, iog_rddata_valid_pre[0]);
            mon_lane(1, iog_rddata_valid_pre[1]);
        end
    end

    initial begin
        repeat (3) tick();
        chk("rst_valid", 32'(iog_rddata_valid_pre), 0);
        chk("rst_busy", 32'(lat_busy), 0);
        chk("rst_lat_active", 32'(lat_active), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_err", 32'(lat_err), 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single request, lanes at 3/5
        load(8'h53, 8'h53);
        repeat (2) tick();
        send(1);
        s = cyc;
        chk("t1_inflight_start", 32'(inflight), 1);
        repeat (4) tick();
        chk("t1_inflight_s4", 32'(inflight), 1);
        tick();
        chk("t1_inflight_s5", 32'(inflight), 1);
        tick();
        chk("t1_inflight_s6", 32'(inflight), 0);
        repeat (3) tick();

        // Burst of 4 at latency 2
        load(8'h22, 8'h22);
        peak = 0;
        send(4);
        chk("t2_inflight_s3", 32'(inflight), 3);
        repeat (3) tick();
        chk("t2_inflight_drained", 32'(inflight), 0);
        chk("t2_inflight_peak", 32'(peak), 3);
        repeat (3) tick();

        // Latency change with two reads in flight
        send(2);
        chk("t3_inflight2", 32'(inflight), 2);
        lane_rd_lat = 8'h77;
        lat_load    = 1'b1;
        tick();
        lat_load = 1'b0;
        chk("t3_busy", 32'(lat_busy), 1);
        chk("t3_lat_old", 32'(lat_active), 32'h22);
        repeat (2) tick();
        chk("t3_inflight0", 32'(inflight), 0);
        chk("t3_still_busy", 32'(lat_busy), 1);
        chk("t3_lat_still_old", 32'(lat_active), 32'h22);
        tick();
        chk("t3_busy_clr", 32'(lat_busy), 0);
        chk("t3_lat_new", 32'(lat_active), 32'h77);
        exp_lat0 = 7;
        exp_lat1 = 7;
        send(1);
        repeat (10) tick();
        chk("t3_drained", 32'(inflight), 0);

        // Illegal code clamp and sticky error
        chk("t4_err_before", 32'(lat_err), 0);
        load(8'h4F, 8'h47);
        chk("t4_err_set", 32'(lat_err), 1);
        load(8'h33, 8'h33);
        chk("t4_err_sticky", 32'(lat_err), 1);

        // Lane 0 disabled, lane 1 fastest-and-only enabled
        lane_enable = 2'b10;
        load(8'h25, 8'h25);
        send(4);
        chk("t5_inflight_s3", 32'(inflight), 3);
        repeat (3) tick();
        chk("t5_inflight_s6", 32'(inflight), 0);
        repeat (6) tick();

        // All lanes disabled: retire at the last stage
        lane_enable = 2'b00;
        send(1);
        chk("t5b_inflight_start", 32'(inflight), 1);
        repeat (7) tick();
        chk("t5b_inflight_s7", 32'(inflight), 1);
        tick();
        chk("t5b_inflight_s8", 32'(inflight), 0);
        lane_enable = 2'b11;
        repeat (2) tick();

        // Reset mid-burst
        load(8'h33, 8'h33);
        send(3);
        repeat (2) tick();
        chk("t6_valid_pre_rst", 32'(iog_rddata_valid_pre), 3);
        chk("t6_inflight_pre_rst", 32'(inflight), 2);
        reset_n = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(iog_rddata_valid_pre), 0);
        chk("t6_inflight_rst", 32'(inflight), 0);
        chk("t6_lat_rst", 32'(lat_active), 0);
        chk("t6_err_rst", 32'(lat_err), 0);
        q0.delete();
        q1.delete();
        exp_lat0 = 0;
        exp_lat1 = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (8) tick();
        chk("t6_inflight_after", 32'(inflight), 0);

`ifdef RD_VALID_GEN_STATS_EN
        chk("st_cnt0_rst", 32'(lane_valid_cnt[15:0]), 0);
        chk("st_cnt1_rst", 32'(lane_valid_cnt[31:16]), 0);
        send(4);
        repeat (4) tick();
        chk("st_cnt0_burst", 32'(lane_valid_cnt[15:0]), 4);
        chk("st_cnt1_burst", 32'(lane_valid_cnt[31:16]), 4);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("st_cnt0_clr", 32'(lane_valid_cnt[15:0]), 0);
        chk("st_cnt1_clr", 32'(lane_valid_cnt[31:16]), 0);
`else
        send(4);
        repeat (4) tick();
`endif
        chk("end_inflight", 32'(inflight), 0);
        chk("end_q0_empty", 32'(q0.size()), 0);
        chk("end_q1_empty", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rd_valid_gen.md
Name: rd_valid_gen

Overview:
- Per-lane read-valid generator, directly upstream of the lane-alignment stage.
- Delays the controller's single dfi_rddata_en by a trained, per-lane read latency, producing iog_rddata_valid_pre[lane] in step with each lane's IOG read data.
- Applies latency updates safely, only when the delay pipeline is empty, and reports pipeline occupancy and update status to training/APB logic.

Parameters:
- IOG_DQS_LANES, 2, number of byte lanes.
- MAX_LAT, 16, depth of each per-lane delay line, in SCLK cycles.
- LAT_WIDTH, 4, width of each lane latency code; must satisfy 2^LAT_WIDTH >= MAX_LAT.
- CNT_WIDTH, 5, width of the in-flight counter; must hold MAX_LAT.

Ports:
- SCLK  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- dfi_rddata_en  in  1  read burst slot request from the controller, one per SCLK
- lane_rd_lat  in  IOG_DQS_LANES*LAT_WIDTH  requested latency per lane; lane i occupies [i*LAT_WIDTH +: LAT_WIDTH]
- lat_load  in  1  single-cycle pulse; capture lane_rd_lat as the pending latency
- lane_enable  in  IOG_DQS_LANES  per-lane output enable
- iog_rddata_valid_pre  out  IOG_DQS_LANES  delayed valid per lane, registered
- lat_busy  out  1  a latency update is pending, not yet applied
- lat_active  out  IOG_DQS_LANES*LAT_WIDTH  latency currently in use
- inflight  out  CNT_WIDTH  number of requests inside the delay lines
- lat_err  out  1  sticky; set when a latency code >= MAX_LAT is loaded

Behaviour:
- Reset state (all outputs and registers): iog_rddata_valid_pre=0, lat_busy=0, lat_active=0, inflight=0, lat_err=0, all delay lines cleared, FSM in S_RUN.
- Delay line per lane: shift register of MAX_LAT bits; bit 0 loads dfi_rddata_en every cycle.
- Output: iog_rddata_valid_pre[i] <= sr[i][lat_active_i] & lane_enable[i].
- Latency: a request sampled at cycle t appears on the output at t+lat_active_i+1. Code 0 gives one cycle of latency.
- inflight:
  - +1 when dfi_rddata_en=1.
  - -1 when the request reaches the output of the slowest enabled lane's tap.
  - Simultaneous +1/-1 leaves it unchanged.
  - Saturates at 2^CNT_WIDTH-1, which cannot be reached with legal use.
  - If all lanes are disabled, decrements at tap MAX_LAT-1.
- FSM states: S_RUN and S_PEND.
  - S_RUN, lat_load=1: capture lane_rd_lat into pend_lat, go to S_PEND, lat_busy=1 next cycle.
  - S_PEND: apply pend_lat to lat_active in the first cycle where inflight==0 and dfi_rddata_en==0, then return to S_RUN (lat_busy=0 that cycle+1).
  - S_PEND, new lat_load: overwrite pend_lat and stay in S_PEND; last load wins.
  - Continuous reads starve the update; the controller must insert one idle slot. No timeout.
- Illegal codes: any code >= MAX_LAT is clamped to MAX_LAT-1 at capture, and lat_err is set. lat_err clears only on reset.
- lane_enable deassert: masks the output immediately at the next registered output, with no pipeline flush. Masked pulses still count for inflight.
- reset_n assert mid-burst: all pending valids are lost; no output pulses after reset release until new requests arrive.

Optional Feature:
- Macro: RD_VALID_GEN_STATS_EN.
- Defined:
  - Adds output lane_valid_cnt (IOG_DQS_LANES*16) and input stats_clr.
  - Per-lane 16-bit saturating counter, incremented on each iog_rddata_valid_pre[i]=1.
  - Synchronous clear on stats_clr (clear wins over increment); reset value 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package rd_valid_gen_pkg holds:
  - FSM state encoding: S_RUN=1'b0, S_PEND=1'b1.
  - Default MAX_LAT / LAT_WIDTH constants.
  - The clamp function for latency codes.
- One natural sub-module, rd_valid_dly_lane:
  - Contains one lane's shift register, tap mux and output register.
  - Instantiated IOG_DQS_LANES times in a generate loop.
- FSM and inflight counter stay at top level.

Test Plan:
- Reset, then load lat=3/5 (lanes 0/1) with no traffic; single dfi_rddata_en at cycle 10 -> lane0 valid at cycle 14, lane1 at cycle 16, one cycle each; inflight 1 from cycle 11, back to 0 after cycle 16.
- Burst of 4 consecutive dfi_rddata_en with lat=2 on both lanes -> 4 consecutive valid pulses on both lanes starting 3 cycles after the first request; inflight peaks at 3 (t+3, after first exit).
- lat_load to 7 while 2 reads are in flight -> lat_busy=1; old latency still used for the in-flight reads; lat_active=7 only after inflight=0 and one idle slot; lat_busy drops the following cycle.
- lat_load code 15 with MAX_LAT=8 -> lat_active=7, lat_err=1; lat_err stays set after a later legal load.
- lane_enable=2'b10 during a burst -> lane0 output stays 0, lane1 pulses normally; inflight still returns to 0.
- Reset pulse mid-burst (2 in flight) -> outputs 0 immediately, no stray pulses after release; with RD_VALID_GEN_STATS_EN, counts read 0 after reset and 4 after one 4-request burst on each enabled lane.
